// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle on a shared
// shift/add-subtract datapath, with a sign fix-up cycle before completion.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            start,
   input  logic [2:0]      func,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        func_q, func_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   mag_q, mag_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, neg_d;
   logic              rem_neg_q, rem_neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Launch-time operand decode
   logic            is_div_in, a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, special;

   always_comb begin
      is_div_in = func[2];
      a_signed  = (func == 3'd1) || (func == 3'd2) || (func == 3'd4) || (func == 3'd6);
      b_signed  = (func == 3'd1) || (func == 3'd4) || (func == 3'd6);
      a_neg     = a_signed & opA[XLEN-1];
      b_neg     = b_signed & opB[XLEN-1];
      a_mag     = a_neg ? (~opA) + XLEN'(1) : opA;
      b_mag     = b_neg ? (~opB) + XLEN'(1) : opB;
      div_zero  = (opB == '0);
      div_ovf   = ((func == 3'd4) || (func == 3'd6)) &&
                  (opA == {1'b1, {(XLEN-1){1'b0}}}) && (&opB);
      special   = is_div_in && (div_zero || div_ovf);
   end

   // Shared datapath: acc holds {hi, lo} = product or {remainder, quotient}
   logic              is_div_q;
   logic [XLEN-1:0]   acc_hi, acc_lo;
   logic [XLEN:0]     rem_sh, add_a, add_b;
   logic [XLEN+1:0]   sum;

   always_comb begin
      is_div_q = func_q[2];
      acc_hi   = acc_q[2*XLEN-1:XLEN];
      acc_lo   = acc_q[XLEN-1:0];
      rem_sh   = {acc_hi, acc_lo[XLEN-1]};
      add_a    = is_div_q ? rem_sh : {1'b0, acc_hi};
      if (is_div_q) begin
         add_b = ~{1'b0, mag_q};
      end else if (acc_lo[0]) begin
         add_b = {1'b0, mag_q};
      end else begin
         add_b = '0;
      end
      // For divide, bit XLEN+1 is the no-borrow flag of rem_sh - divisor
      sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div_q};
   end

   // Sign fix-up and result selection
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

   always_comb begin
      prod_fix = neg_q ? (~acc_q) + (2*XLEN)'(1) : acc_q;
      quot_fix = neg_q ? (~acc_lo) + XLEN'(1) : acc_lo;
      rem_fix  = rem_neg_q ? (~acc_hi) + XLEN'(1) : acc_hi;
      case (func_q)
         3'd0:                 fix_val = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:     fix_val = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:           fix_val = quot_fix;
         default:              fix_val = rem_fix;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      func_d    = func_q;
      cnt_d     = cnt_q;
      mag_d     = mag_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start && !kill) begin
               func_d    = func;
               cnt_d     = CW'(XLEN-1);
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = 1'b0;
               state_d   = special ? FIX : ITER;
               if (!is_div_in) begin
                  mag_d = a_mag;
                  acc_d = {{XLEN{1'b0}}, b_mag};
               end else if (div_zero) begin
                  // Preloaded so FIX passes the special results through untouched
                  neg_d = 1'b0;
                  acc_d = {opA, {XLEN{1'b1}}};
               end else if (div_ovf) begin
                  neg_d = 1'b0;
                  acc_d = {{XLEN{1'b0}}, opA};
               end else begin
                  mag_d     = b_mag;
                  acc_d     = {{XLEN{1'b0}}, a_mag};
                  rem_neg_d = a_neg;
               end
            end
         end
         ITER: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  if (sum[XLEN+1]) begin
                     acc_d = {sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
                  end else begin
                     acc_d = {rem_sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
                  end
               end else begin
                  acc_d = {sum[XLEN:0], acc_lo[XLEN-1:1]};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               result_d = fix_val;
               state_d  = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= IDLE;
         func_q    <= '0;
         cnt_q     <= '0;
         mag_q     <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         func_q    <= func_d;
         cnt_q     <= cnt_d;
         mag_q     <= mag_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q == ITER) || (state_q == FIX);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results and done
// cycles, a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic              clock = 1'b0;
   logic              clear, start, kill;
   logic [2:0]        func;
   logic [XLEN-1:0]   opA, opB;
   logic              busy, done;
   logic [XLEN-1:0]   result;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clock  (clock),
      .clear  (clear),
      .start  (start),
      .func   (func),
      .opA    (opA),
      .opB    (opB),
      .kill   (kill),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      int          fn;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] last_result = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference model written directly from the RV32M arithmetic rules
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) ||
             (((f == 3'd4) || (f == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   always @(negedge clock) begin : monitor
      exp_t e;
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            $display("txn func=%0d result=%h expected=%h done_cycle=%0d expected_cycle=%0d",
                     e.fn, result, e.res, cyc, e.cyc);
            check("result", result, e.res);
            check("done_latency", cyc, e.cyc);
            last_result = e.res;
         end
      end
   end

   // Called at posedge+1; waits for busy low, drives start for one cycle.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_it, input logic [31:0] exp_res, output int s);
      int   n;
      exp_t e;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("issue_ready", busy, 0);
      func  = f;
      opA   = a;
      opB   = b;
      start = 1'b1;
      s     = cyc;
      if (expect_it) begin
         e.res = exp_res;
         e.cyc = cyc + (is_special(f, a, b) ? 2 : XLEN + 2);
         e.fn  = int'(f);
         sbq.push_back(e);
      end
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   initial begin
      int          s, n, sel;
      logic [2:0]  f;
      logic [31:0] a, b;

      clear = 1'b1; start = 1'b0; kill = 1'b0;
      func  = '0;   opA = '0;     opB = '0;
      repeat (2) begin @(posedge clock); #1; end
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      clear = 1'b0;
      @(posedge clock); #1;

      // MUL with busy profile across the whole operation
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, s);
      for (int k = 1; k <= XLEN + 2; k++) begin
         @(negedge clock);
         check("busy_profile", busy, (k <= XLEN + 1) ? 1 : 0);
      end
      @(posedge clock); #1;

      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, s);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, s);
      // rs1 signed, rs2 unsigned: -1 * 2 = -2, upper word all ones
      issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, s);

      // Divide group, back-to-back from each DONE cycle
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, s);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, s);
      issue(3'd5, 32'd100, 32'd7, 1, 32'd14, s);
      issue(3'd7, 32'd100, 32'd7, 1, 32'd2, s);

      // Special cases
      issue(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, s);
      issue(3'd6, 32'd5, 32'd0, 1, 32'd5, s);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, s);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, s);

      // Kill on cycle 10, then start masked by kill, then start on cycle 12
      issue(3'd4, 32'd12345, 32'd17, 0, '0, s);
      repeat (9) begin @(posedge clock); #1; end
      kill = 1'b1;
      @(posedge clock); #1;
      kill = 1'b0;
      check("kill_busy", busy, 0);
      check("kill_result_held", result, last_result);
      start = 1'b1; kill = 1'b1; func = 3'd5; opA = 32'd9; opB = 32'd3;
      @(posedge clock); #1;
      start = 1'b0; kill = 1'b0;
      check("start_with_kill_ignored", busy, 0);
      check("start_with_kill_cycle", cyc - s, 12);
      issue(3'd5, 32'd1000, 32'd3, 1, 32'd333, s);

      // Start while busy must not disturb the running operation
      issue(3'd0, 32'h0001_2345, 32'h0000_6789, 1, ref_model(3'd0, 32'h0001_2345, 32'h0000_6789), s);
      start = 1'b1; func = 3'd4; opA = $urandom; opB = $urandom;
      repeat (5) begin @(posedge clock); #1; end
      start = 1'b0;

      // Asynchronous clear in cycle 15 of a MUL
      issue(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0, '0, s);
      repeat (14) begin @(posedge clock); #1; end
      clear = 1'b1;
      #1;
      check("clear_busy", busy, 0);
      check("clear_done", done, 0);
      check("clear_result", result, 0);
      last_result = '0;
      #1;
      clear = 1'b0;
      @(posedge clock); #1;
      issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), s);

      // Randomized operations with a bias toward the divide corner cases
      for (int i = 0; i < 40; i++) begin
         f   = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            3: begin a = -$urandom_range(1, 50); b = -$urandom_range(1, 9); end
            4: a = 32'h8000_0000;
            default: ;
         endcase
         issue(f, a, b, 1, ref_model(f, a, b), s);
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end

      n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("scoreboard_drained", sbq.size(), 0);
      repeat (4) begin @(posedge clock); #1; end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
